axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-port AXI-lite memory slave, directly downstream of the two-master SRAM arbiter.
- Serves all instruction-fetch and load/store traffic from the core.
- Backed by an internal DEPTH x 64-bit word array.
- Programmable read and write latency lets the bench stress IFU/EXU stall paths.
- One transaction outstanding at a time; writes take priority over reads.

Parameters:
- DEPTH, 4096: number of 64-bit words; must be a power of two.
- RD_LAT, 2: cycles from AR handshake to R_VALID; minimum 1.
- WR_LAT, 1: cycles from the later of the AW/W handshakes to B_VALID; minimum 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- axi_AW_ADDR  in  64  write address (byte).
- axi_AW_VALID  in  1  write address valid.
- axi_AW_READY  out  1  write address accepted.
- axi_W_DATA  in  64  write data.
- axi_W_STRB  in  8  byte enables; bit i covers W_DATA[8i+7:8i].
- axi_W_VALID  in  1  write data valid.
- axi_W_READY  out  1  write data accepted.
- axi_B_VALID  out  1  write response valid.
- axi_B_READY  in  1  write response taken.
- axi_AR_ADDR  in  64  read address (byte).
- axi_AR_VALID  in  1  read address valid.
- axi_AR_READY  out  1  read address accepted.
- axi_R_DATA  out  64  read data.
- axi_R_VALID  out  1  read data valid.
- axi_R_READY  in  1  read data taken.

Behaviour:
- Reset:
  - State = IDLE; latency counter = 0; aw_got = w_got = 0.
  - While rst = 1, all READY and VALID outputs = 0 and R_DATA = 0.
  - Memory contents are not reset.
- Word index = ADDR[$clog2(DEPTH)+2:3]. Upper bits are ignored, so out-of-range addresses alias (wrap). ADDR[2:0] is ignored; accesses are always 64-bit aligned.
- States: IDLE, WR_COLLECT, WR_WAIT, WR_RESP, RD_WAIT, RD_RESP.
- IDLE:
  - AW_READY = W_READY = 1.
  - AR_READY = !(AW_VALID | W_VALID), i.e. write priority.
  - Any AW or W handshake: latch addr/data/strb and set aw_got/w_got.
    - Both complete in the same cycle -> WR_WAIT.
    - Only one completes -> WR_COLLECT.
  - Otherwise, an AR handshake latches the address -> RD_WAIT.
  - Simultaneous AR_VALID and AW_VALID: the write wins and AR is not acknowledged that cycle.
- WR_COLLECT:
  - The READY of the already-received channel = 0; the missing channel's READY = 1.
  - On its handshake -> WR_WAIT. AR_READY = 0.
- WR_WAIT:
  - Counter runs 1..WR_LAT.
  - On reaching WR_LAT: write the array with byte merge per strobe. STRB = 0 performs no change but still responds.
  - Then -> WR_RESP.
- WR_RESP:
  - B_VALID = 1 and is held stable until B_READY.
  - On handshake -> IDLE; the next transaction may be accepted the following cycle.
- RD_WAIT:
  - Counter runs 1..RD_LAT.
  - On reaching RD_LAT: register array[index] into R_DATA -> RD_RESP.
  - A read issued after a write returns the written data (no stale data).
- RD_RESP:
  - R_VALID = 1; R_DATA is held stable until R_READY.
  - On handshake -> IDLE.
  - R_DATA keeps its last value after the handshake.
- Throughput:
  - Read round trip = 1 (AR) + RD_LAT + 1 (R) cycles minimum when READY is tied high.
  - Write round trip follows the same pattern with WR_LAT.
- Backpressure: VALID outputs must never drop without a handshake.
- Mid-operation reset: asserting rst in any state returns immediately to IDLE with all outputs 0. The pending transaction is discarded. If the array write had not yet been performed, the array is left untouched.
- No error responses. No BRESP/RRESP ports; OKAY is implied.

Test Plan:
- Write then read:
  - Stimulus: AW 0x8000_0010 / W 0x1122334455667788, STRB 0xFF, then AR 0x8000_0010.
  - Required: B_VALID 2 cycles after the W handshake (WR_LAT=1); R_DATA = 0x1122334455667788 exactly RD_LAT+1 cycles after the AR handshake.
- Partial strobe:
  - Stimulus: pre-write 0xFFFF_FFFF_FFFF_FFFF; write 0x0 with STRB 0x0F; read back.
  - Required: 0xFFFF_FFFF_0000_0000.
- Split AW/W:
  - Stimulus: W valid 3 cycles before AW.
  - Required: W_READY drops after the W handshake; AR_READY stays 0 until B completes; write lands correctly.
- Simultaneous AR and AW in IDLE:
  - Required: write accepted first; AR_READY stays 0; read is served after B, and its data reflects the new write.
- Backpressure:
  - Stimulus: hold R_READY = 0 for 5 cycles.
  - Required: R_VALID stays 1 and R_DATA stays constant; B channel behaves identically under B_READY = 0.
- Alias and reset:
  - Stimulus: with DEPTH=4096, write address 0x8000 aliases index 0; assert rst during RD_WAIT.
  - Required: alias read returns index-0 data; after rst all outputs = 0, state = IDLE, and a new read completes normally.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI-lite single-port SRAM slave with programmable read/write latency.
// One transaction in flight at a time; a pending write always beats a read.
module axi_sram_slave #(
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] axi_AW_ADDR,
  input  logic        axi_AW_VALID,
  output logic        axi_AW_READY,
  input  logic [63:0] axi_W_DATA,
  input  logic [7:0]  axi_W_STRB,
  input  logic        axi_W_VALID,
  output logic        axi_W_READY,
  output logic        axi_B_VALID,
  input  logic        axi_B_READY,
  input  logic [63:0] axi_AR_ADDR,
  input  logic        axi_AR_VALID,
  output logic        axi_AR_READY,
  output logic [63:0] axi_R_DATA,
  output logic        axi_R_VALID,
  input  logic        axi_R_READY
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RD_LAT_C = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LAT_C = CNT_W'(WR_LAT);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_COLLECT = 3'd1;
  localparam logic [2:0] WR_WAIT    = 3'd2;
  localparam logic [2:0] WR_RESP    = 3'd3;
  localparam logic [2:0] RD_WAIT    = 3'd4;
  localparam logic [2:0] RD_RESP    = 3'd5;

  logic [63:0]      r_mem [DEPTH];
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_aw_got;
  logic             r_w_got;
  logic [IDX_W-1:0] r_addr;
  logic [63:0]      r_wdata;
  logic [7:0]       r_wstrb;
  logic [63:0]      r_rdata;

  logic [CNT_W-1:0] w_cnt_next;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_ar_hs;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_aw_idx;
  logic [IDX_W-1:0] w_ar_idx;
  logic             w_unused_addr_bits;

  // Only the word-index bits of the byte address matter; the rest alias away.
  assign w_aw_idx = axi_AW_ADDR[IDX_W+2:3];
  assign w_ar_idx = axi_AR_ADDR[IDX_W+2:3];
  assign w_unused_addr_bits = ^{axi_AW_ADDR[63:IDX_W+3], axi_AW_ADDR[2:0],
                                axi_AR_ADDR[63:IDX_W+3], axi_AR_ADDR[2:0]};

  // Handshake outputs are decoded from state and forced low while reset is held.
  assign axi_AW_READY = !rst && ((r_state == IDLE) || ((r_state == WR_COLLECT) && !r_aw_got));
  assign axi_W_READY  = !rst && ((r_state == IDLE) || ((r_state == WR_COLLECT) && !r_w_got));
  assign axi_AR_READY = !rst && (r_state == IDLE) && !(axi_AW_VALID || axi_W_VALID);
  assign axi_B_VALID  = !rst && (r_state == WR_RESP);
  assign axi_R_VALID  = !rst && (r_state == RD_RESP);
  assign axi_R_DATA   = r_rdata;

  assign w_aw_hs    = axi_AW_VALID && axi_AW_READY;
  assign w_w_hs     = axi_W_VALID && axi_W_READY;
  assign w_ar_hs    = axi_AR_VALID && axi_AR_READY;
  assign w_cnt_next = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_mem_we   = !rst && (r_state == WR_WAIT) && (w_cnt_next == WR_LAT_C);

  // Transaction FSM: collects AW/W, counts latency, and holds responses until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_rdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_aw_hs || w_w_hs) begin
            if (w_aw_hs) begin
              r_addr   <= w_aw_idx;
              r_aw_got <= 1'b1;
            end
            if (w_w_hs) begin
              r_wdata <= axi_W_DATA;
              r_wstrb <= axi_W_STRB;
              r_w_got <= 1'b1;
            end
            r_cnt   <= '0;
            r_state <= (w_aw_hs && w_w_hs) ? WR_WAIT : WR_COLLECT;
          end else if (w_ar_hs) begin
            r_addr  <= w_ar_idx;
            r_cnt   <= '0;
            r_state <= RD_WAIT;
          end
        end
        WR_COLLECT: begin
          if (w_aw_hs) begin
            r_addr   <= w_aw_idx;
            r_aw_got <= 1'b1;
          end
          if (w_w_hs) begin
            r_wdata <= axi_W_DATA;
            r_wstrb <= axi_W_STRB;
            r_w_got <= 1'b1;
          end
          if (w_aw_hs || w_w_hs) begin
            r_cnt   <= '0;
            r_state <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (w_cnt_next == WR_LAT_C) begin
            r_cnt   <= '0;
            r_state <= WR_RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        WR_RESP: begin
          if (axi_B_READY) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD_WAIT: begin
          if (w_cnt_next == RD_LAT_C) begin
            r_rdata <= r_mem[r_addr];
            r_cnt   <= '0;
            r_state <= RD_RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        RD_RESP: begin
          if (axi_R_READY) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Array update with per-byte strobe merge at the end of the write latency.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int i = 0; i < 8; i++) begin
        if (r_wstrb[i]) begin
          r_mem[r_addr][8*i +: 8] <= r_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: stimulus pushes expected responses,
// a negedge monitor pops and compares them as the DUT hands them over.
module tb_axi_sram_slave;

  localparam int DEPTH  = 4096;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;

  logic        clk;
  logic        rst;
  logic [63:0] axi_AW_ADDR;
  logic        axi_AW_VALID;
  logic        axi_AW_READY;
  logic [63:0] axi_W_DATA;
  logic [7:0]  axi_W_STRB;
  logic        axi_W_VALID;
  logic        axi_W_READY;
  logic        axi_B_VALID;
  logic        axi_B_READY;
  logic [63:0] axi_AR_ADDR;
  logic        axi_AR_VALID;
  logic        axi_AR_READY;
  logic [63:0] axi_R_DATA;
  logic        axi_R_VALID;
  logic        axi_R_READY;

  int testsRun = 0;
  int testsFailed = 0;

  logic [63:0] rQ[$];
  bit          bQ[$];

  axi_sram_slave #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .rst(rst),
    .axi_AW_ADDR(axi_AW_ADDR), .axi_AW_VALID(axi_AW_VALID), .axi_AW_READY(axi_AW_READY),
    .axi_W_DATA(axi_W_DATA), .axi_W_STRB(axi_W_STRB), .axi_W_VALID(axi_W_VALID),
    .axi_W_READY(axi_W_READY),
    .axi_B_VALID(axi_B_VALID), .axi_B_READY(axi_B_READY),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case some handshake never arrives.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
    testsRun++;
    if (actual !== required) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual %h required %h", name, actual, required);
    end
  endtask

  // Monitor: every completed R or B handshake must match the head of its queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_R_VALID && axi_R_READY) begin
        if (rQ.size() == 0) checkOutput("r_unexpected", 64'd1, 64'd0);
        else checkOutput("r_data", axi_R_DATA, rQ.pop_front());
      end
      if (axi_B_VALID && axi_B_READY) begin
        if (bQ.size() == 0) checkOutput("b_unexpected", 64'd1, 64'd0);
        else checkOutput("b_resp", 64'(bQ.pop_front()), 64'd1);
      end
    end
  end

  // Waits for B_VALID after the last write handshake edge; optionally checks AR is blocked.
  task automatic waitB(input bit checkAr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (checkAr) checkOutput("ar_ready_blocked_by_write", 64'(axi_AR_READY), 64'd0);
    end while (!axi_B_VALID && n < 50);
    checkOutput("b_latency", 64'(n), 64'(WR_LAT + 1));
  endtask

  // Drives AW and W together, completes both handshakes and waits for B.
  task automatic applyWrite(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    int n;
    bit awDone, wDone, awHs, wHs;
    axi_AW_ADDR = addr; axi_AW_VALID = 1'b1;
    axi_W_DATA = data; axi_W_STRB = strb; axi_W_VALID = 1'b1;
    awDone = 0; wDone = 0; n = 0;
    while (!(awDone && wDone) && n < 50) begin
      @(negedge clk);
      awHs = axi_AW_VALID && axi_AW_READY;
      wHs  = axi_W_VALID && axi_W_READY;
      @(posedge clk); #1;
      if (awHs) begin awDone = 1; axi_AW_VALID = 1'b0; end
      if (wHs)  begin wDone = 1;  axi_W_VALID = 1'b0; end
      n++;
    end
    axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
    if (!(awDone && wDone)) begin
      checkOutput("write_handshake_timeout", 64'd1, 64'd0);
      return;
    end
    bQ.push_back(1'b1);
    waitB(1'b0);
    if (axi_B_READY) begin @(posedge clk); #1; end
  endtask

  // Drives AR until accepted, queues the expected data and checks R latency.
  task automatic applyRead(input logic [63:0] addr, input logic [63:0] expData);
    int n;
    bit hs;
    axi_AR_ADDR = addr; axi_AR_VALID = 1'b1;
    hs = 0; n = 0;
    while (!hs && n < 50) begin
      @(negedge clk);
      hs = axi_AR_READY;
      @(posedge clk); #1;
      n++;
    end
    axi_AR_VALID = 1'b0;
    if (!hs) begin
      checkOutput("ar_handshake_timeout", 64'd1, 64'd0);
      return;
    end
    rQ.push_back(expData);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!axi_R_VALID && n < 50);
    checkOutput("r_latency", 64'(n), 64'(RD_LAT + 1));
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    axi_AW_ADDR = '0; axi_AW_VALID = 1'b0;
    axi_W_DATA = '0; axi_W_STRB = '0; axi_W_VALID = 1'b0;
    axi_AR_ADDR = '0; axi_AR_VALID = 1'b0;
    axi_B_READY = 1'b1; axi_R_READY = 1'b1;

    // Reset state: everything low
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_aw_ready", 64'(axi_AW_READY), 64'd0);
    checkOutput("rst_w_ready", 64'(axi_W_READY), 64'd0);
    checkOutput("rst_ar_ready", 64'(axi_AR_READY), 64'd0);
    checkOutput("rst_b_valid", 64'(axi_B_VALID), 64'd0);
    checkOutput("rst_r_valid", 64'(axi_R_VALID), 64'd0);
    checkOutput("rst_r_data", axi_R_DATA, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_aw_ready", 64'(axi_AW_READY), 64'd1);
    checkOutput("idle_ar_ready", 64'(axi_AR_READY), 64'd1);
    @(posedge clk); #1;

    // Write then read
    applyWrite(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF);
    applyRead(64'h8000_0010, 64'h1122_3344_5566_7788);

    // Partial strobe: only low four bytes cleared
    applyWrite(64'h0000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    applyWrite(64'h0000_0100, 64'h0, 8'h0F);
    applyRead(64'h0000_0100, 64'hFFFF_FFFF_0000_0000);

    // Zero strobe: still responds, word unchanged
    applyWrite(64'h0000_0100, 64'h0, 8'h00);
    applyRead(64'h0000_0100, 64'hFFFF_FFFF_0000_0000);

    // Split AW/W: W first, AW three cycles later
    axi_W_DATA = 64'hA5A5_5A5A_0F0F_F0F0; axi_W_STRB = 8'hFF; axi_W_VALID = 1'b1;
    @(negedge clk);
    checkOutput("split_w_ready_idle", 64'(axi_W_READY), 64'd1);
    @(posedge clk); #1 axi_W_VALID = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checkOutput("split_w_ready_dropped", 64'(axi_W_READY), 64'd0);
      checkOutput("split_aw_ready_open", 64'(axi_AW_READY), 64'd1);
      checkOutput("split_ar_ready", 64'(axi_AR_READY), 64'd0);
      @(posedge clk); #1;
    end
    axi_AW_ADDR = 64'h0000_0200; axi_AW_VALID = 1'b1;
    @(negedge clk);
    checkOutput("split_aw_ready", 64'(axi_AW_READY), 64'd1);
    checkOutput("split_w_ready_still_low", 64'(axi_W_READY), 64'd0);
    @(posedge clk); #1 axi_AW_VALID = 1'b0;
    bQ.push_back(1'b1);
    waitB(1'b1);
    @(posedge clk); #1;
    applyRead(64'h0000_0200, 64'hA5A5_5A5A_0F0F_F0F0);

    // Simultaneous AR and AW/W in IDLE: the write goes first
    axi_AW_ADDR = 64'h0000_0300; axi_AW_VALID = 1'b1;
    axi_W_DATA = 64'hDEAD_BEEF_CAFE_F00D; axi_W_STRB = 8'hFF; axi_W_VALID = 1'b1;
    axi_AR_ADDR = 64'h0000_0300; axi_AR_VALID = 1'b1;
    @(negedge clk);
    checkOutput("simul_ar_ready", 64'(axi_AR_READY), 64'd0);
    checkOutput("simul_aw_ready", 64'(axi_AW_READY), 64'd1);
    checkOutput("simul_w_ready", 64'(axi_W_READY), 64'd1);
    @(posedge clk); #1 axi_AW_VALID = 1'b0; axi_W_VALID = 1'b0;
    bQ.push_back(1'b1);
    waitB(1'b1);
    @(posedge clk); #1;
    applyRead(64'h0000_0300, 64'hDEAD_BEEF_CAFE_F00D);

    // R backpressure: R_VALID and R_DATA held for 5 cycles
    axi_R_READY = 1'b0;
    applyRead(64'h8000_0010, 64'h1122_3344_5566_7788);
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_r_valid", 64'(axi_R_VALID), 64'd1);
      checkOutput("bp_r_data", axi_R_DATA, 64'h1122_3344_5566_7788);
      @(posedge clk); #1;
    end
    axi_R_READY = 1'b1;
    @(posedge clk); #1;

    // B backpressure: B_VALID held for 5 cycles
    axi_B_READY = 1'b0;
    applyWrite(64'h0000_0400, 64'h0BAD_F00D_1234_5678, 8'hFF);
    @(posedge clk); #1;
    repeat (5) begin
      @(negedge clk);
      checkOutput("bp_b_valid", 64'(axi_B_VALID), 64'd1);
      @(posedge clk); #1;
    end
    axi_B_READY = 1'b1;
    @(posedge clk); #1;
    applyRead(64'h0000_0400, 64'h0BAD_F00D_1234_5678);

    // Alias: 0x8000 wraps to word 0 with DEPTH=4096
    applyWrite(64'h0000_8000, 64'h0123_4567_89AB_CDEF, 8'hFF);
    applyRead(64'h0000_0000, 64'h0123_4567_89AB_CDEF);

    // Reset during RD_WAIT discards the read
    axi_AR_ADDR = 64'h0000_0000; axi_AR_VALID = 1'b1;
    @(negedge clk);
    checkOutput("rst_test_ar_ready", 64'(axi_AR_READY), 64'd1);
    @(posedge clk); #1 axi_AR_VALID = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_aw_ready", 64'(axi_AW_READY), 64'd0);
    checkOutput("midrst_ar_ready", 64'(axi_AR_READY), 64'd0);
    checkOutput("midrst_r_valid", 64'(axi_R_VALID), 64'd0);
    checkOutput("midrst_r_data", axi_R_DATA, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("postrst_r_valid", 64'(axi_R_VALID), 64'd0);
      checkOutput("postrst_aw_ready", 64'(axi_AW_READY), 64'd1);
    end
    @(posedge clk); #1;
    applyRead(64'h8000_0010, 64'h1122_3344_5566_7788);

    // Let the monitor drain outstanding expectations
    n = 0;
    while ((rQ.size() != 0 || bQ.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("scoreboard_drain", 64'(rQ.size() + bQ.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
